// File: rtl/n_bitadder_pkg.sv
// Shared definitions for the chunked serial subtractor: FSM state
// encoding, default operand/chunk widths and a small sizing helper.
package n_bitadder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_N     = 32;
    localparam int DEFAULT_CHUNK = 4;

    // Number of RUN cycles needed to sweep an n-bit operand c bits at a time.
    function automatic int chunkCount(input int n, input int c);
        return n / c;
    endfunction

endpackage

// File: rtl/n_bitsub_chunk.sv
// One CHUNK-bit slice of a two's-complement subtractor: a + ~b + cin.
// The carry out is the inverse of the borrow out of this slice.
module n_bitsub_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] diff,
    output logic         cout
);

    logic [W:0] sum;

    // Widen by one bit so the top bit of the sum carries into the next slice.
    always_comb begin
        sum  = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
        diff = sum[W-1:0];
        cout = sum[W];
    end

endmodule

// File: rtl/n_bitsubtractor.sv
// Multi-cycle N-bit subtractor: answer = input1 - input2 (mod 2^N),
// computed CHUNK bits per clock with a valid/ready handshake on both sides.
// Optional signed-overflow output enabled by defining N_BITSUB_OVF_EN.
// N must be an integer multiple of CHUNK.
module n_bitsubtractor
    import n_bitadder_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] input1,
    input  logic [N-1:0] input2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] answer,
    output logic         borrow
`ifdef N_BITSUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int NumChunks = chunkCount(N, CHUNK);
    localparam int IdxW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumChunks - 1);

    state_t          state_q;
    logic [N-1:0]    opA_q;
    logic [N-1:0]    opB_q;
    logic [N-1:0]    answer_q;
    logic [IdxW-1:0] chunkIdx_q;
    logic            carry_q;
    logic            outValid_q;
    logic            borrow_q;
    logic            borrow_d;

    logic [CHUNK-1:0] chunkA;
    logic [CHUNK-1:0] chunkB;
    logic [CHUNK-1:0] chunkDiff;
    logic             chunkCout;
    logic             lastChunk;

    // Select the operand slices addressed by the current chunk index.
    always_comb begin
        chunkA    = opA_q[int'(chunkIdx_q) * CHUNK +: CHUNK];
        chunkB    = opB_q[int'(chunkIdx_q) * CHUNK +: CHUNK];
        lastChunk = (chunkIdx_q == LastIdx);
        borrow_d  = ~chunkCout;
    end

    n_bitsub_chunk #(
        .W (CHUNK)
    ) u_chunk (
        .a    (chunkA),
        .b    (chunkB),
        .cin  (carry_q),
        .diff (chunkDiff),
        .cout (chunkCout)
    );

`ifdef N_BITSUB_OVF_EN
    logic ovf_q;
    logic ovf_d;

    // Signed overflow: operands of opposite sign and the result sign differs
    // from the minuend; the result sign bit comes out of the last slice.
    always_comb begin
        ovf_d = (opA_q[N-1] != opB_q[N-1]) && (chunkDiff[CHUNK-1] != opA_q[N-1]);
    end

    assign ovf = ovf_q;
`endif

    // Single FSM: accept operands, sweep chunks LSB first, hold result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            opA_q      <= '0;
            opB_q      <= '0;
            answer_q   <= '0;
            chunkIdx_q <= '0;
            carry_q    <= 1'b0;
            outValid_q <= 1'b0;
            borrow_q   <= 1'b0;
`ifdef N_BITSUB_OVF_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        opA_q      <= input1;
                        opB_q      <= input2;
                        chunkIdx_q <= '0;
                        carry_q    <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    answer_q[int'(chunkIdx_q) * CHUNK +: CHUNK] <= chunkDiff;
                    carry_q    <= chunkCout;
                    chunkIdx_q <= chunkIdx_q + 1'b1;
                    if (lastChunk) begin
                        chunkIdx_q <= '0;
                        borrow_q   <= borrow_d;
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
`ifdef N_BITSUB_OVF_EN
                        ovf_q      <= ovf_d;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = outValid_q;
    assign answer    = answer_q;
    assign borrow    = borrow_q;

endmodule

// File: tb/tb_n_bitsubtractor.sv
// Self-checking bench for n_bitsubtractor: arithmetic reference model,
// per-cycle output comparison, and literal pinned cases.
// Define N_BITSUB_OVF_EN to also exercise the ovf output.
module tb_n_bitsubtractor;

    localparam int N       = 32;
    localparam int CHUNK   = 4;
    localparam int LAT     = N / CHUNK;
    localparam int TIMEOUT = LAT + 6;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [N-1:0] input1    = '0;
    logic [N-1:0] input2    = '0;
    wire          in_ready;
    wire          out_valid;
    wire  [N-1:0] answer;
    wire          borrow;
`ifdef N_BITSUB_OVF_EN
    wire          ovf;
`endif

    int checksTotal  = 0;
    int checksPassed = 0;

    n_bitsubtractor #(
        .N     (N),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .input1    (input1),
        .input2    (input2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .answer    (answer),
        .borrow    (borrow)
`ifdef N_BITSUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial forever #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic doCheck(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checksTotal++;
        if (act === exp) checksPassed++;
        else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Signed overflow from plain integer arithmetic on sign-extended operands.
    function automatic bit signedOvf(input logic [N-1:0] a, input logic [N-1:0] b);
        longint sa, sb, d, maxV, minV;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        d    = sa - sb;
        maxV = (longint'(1) <<< (N - 1)) - 1;
        minV = -(longint'(1) <<< (N - 1));
        return (d > maxV) || (d < minV);
    endfunction

    // Reference model: busy for LAT clocks after acceptance, then done until taken.
    bit           mBusy     = 1'b0;
    bit           mDone     = 1'b0;
    bit           seenReset = 1'b0;
    int           runLeft   = 0;
    logic [N-1:0] expAns    = '0;
    bit           expBorrow = 1'b0;
    bit           expOvf    = 1'b0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            mBusy     = 1'b0;
            mDone     = 1'b0;
            seenReset = 1'b1;
        end else if (!mBusy) begin
            if (in_valid) begin
                mBusy     = 1'b1;
                runLeft   = LAT;
                expAns    = input1 - input2;
                expBorrow = (input1 < input2);
                expOvf    = signedOvf(input1, input2);
            end
        end else if (!mDone) begin
            runLeft--;
            if (runLeft == 0) mDone = 1'b1;
        end else if (out_ready) begin
            mBusy = 1'b0;
            mDone = 1'b0;
        end
    end

    // Compare process: checks DUT outputs against the model shortly after each edge.
    initial forever begin
        @(posedge clk);
        #2;
        if (seenReset) begin
            if (rst) begin
                doCheck("reset in_ready", in_ready, 0);
                doCheck("reset out_valid", out_valid, 0);
                doCheck("reset answer", answer, 0);
                doCheck("reset borrow", borrow, 0);
`ifdef N_BITSUB_OVF_EN
                doCheck("reset ovf", ovf, 0);
`endif
            end else begin
                doCheck("in_ready", in_ready, !mBusy);
                doCheck("out_valid", out_valid, mDone);
                if (mDone) begin
                    doCheck("answer", answer, expAns);
                    doCheck("borrow", borrow, expBorrow);
`ifdef N_BITSUB_OVF_EN
                    doCheck("ovf", ovf, expOvf);
`endif
                end
            end
        end
    end

    int           lastLat    = 0;
    logic [N-1:0] lastAnswer = '0;
    logic         lastBorrow = 1'b0;
    logic         lastOvf    = 1'b0;

    // Noise on the input side while the block is busy; it must be ignored.
    task automatic junk();
        input1   = $urandom;
        input2   = $urandom;
        in_valid = 1'($urandom_range(0, 1));
    endtask

    task automatic waitReady(output bit ok);
        int waitCnt = 0;
        @(negedge clk);
        while (!in_ready && waitCnt < TIMEOUT) begin
            @(negedge clk);
            waitCnt++;
        end
        ok = in_ready;
        if (!ok) doCheck("in_ready wait timeout", in_ready, 1);
    endtask

    // One full transaction: offer operands, scramble inputs while busy,
    // measure latency, hold the result for 'hold' cycles, then take it.
    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input int hold);
        bit ok;
        waitReady(ok);
        if (ok) begin
            input1   = a;
            input2   = b;
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            junk();
            lastLat = 0;
            do begin
                @(posedge clk);
                lastLat++;
                @(negedge clk);
                junk();
            end while (!out_valid && lastLat < TIMEOUT);
            doCheck("latency", lastLat, LAT);
            lastAnswer = answer;
            lastBorrow = borrow;
`ifdef N_BITSUB_OVF_EN
            lastOvf = ovf;
`endif
            repeat (hold) begin
                @(negedge clk);
                junk();
                doCheck("hold answer stable", answer, lastAnswer);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic checkOutput(input string name, input logic [N-1:0] ans, input logic brw);
        doCheck({name, " answer"}, lastAnswer, ans);
        doCheck({name, " borrow"}, lastBorrow, brw);
    endtask

    // Start an operation and hit reset during the 4th RUN cycle.
    task automatic resetMidRun(input logic [N-1:0] a, input logic [N-1:0] b);
        bit ok;
        waitReady(ok);
        if (ok) begin
            input1   = a;
            input2   = b;
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            junk();
            repeat (3) begin
                @(negedge clk);
                junk();
            end
            rst      = 1'b1;
            in_valid = 1'b0;
            @(negedge clk);
            doCheck("abort out_valid", out_valid, 0);
            doCheck("abort answer", answer, 0);
            doCheck("abort borrow", borrow, 0);
            doCheck("abort in_ready in reset", in_ready, 0);
            rst = 1'b0;
            #1;
            doCheck("abort in_ready after reset", in_ready, 1);
        end
    endtask

    logic [N-1:0] ra, rb;

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        applyStimulus(32'd1209, 32'd4565, 0);
        checkOutput("1209-4565", 32'hFFFF_F2E4, 1'b1);
        applyStimulus(32'd4565, 32'd1209, 2);
        checkOutput("4565-1209", 32'h0000_0D1C, 1'b0);
        applyStimulus(32'd0, 32'd1, 1);
        checkOutput("0-1", 32'hFFFF_FFFF, 1'b1);
`ifdef N_BITSUB_OVF_EN
        applyStimulus(32'h8000_0000, 32'd1, 0);
        checkOutput("min-1", 32'h7FFF_FFFF, 1'b0);
        doCheck("min-1 ovf", lastOvf, 1);
        applyStimulus(32'h0000_0005, 32'd3, 0);
        doCheck("5-3 ovf", lastOvf, 0);
`endif
        ra = $urandom;
        applyStimulus(ra, ra, 5);
        checkOutput("equal", 32'h0, 1'b0);
        applyStimulus(32'hFFFF_FFFF, 32'h0, 0);
        checkOutput("max-0", 32'hFFFF_FFFF, 1'b0);
        applyStimulus(32'h0, 32'hFFFF_FFFF, 3);
        checkOutput("0-max", 32'h0000_0001, 1'b1);

        resetMidRun(32'h1234_5678, 32'h0000_1111);
        applyStimulus(32'd7, 32'd7, 0);
        checkOutput("7-7 after abort", 32'h0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = ra;
                1: ra = '0;
                2: rb = '1;
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            applyStimulus(ra, rb, int'($urandom_range(0, 3)));
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, %0d/%0d so far", checksPassed, checksTotal);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/n_bitsubtractor.md
N_BITSUBTRACTOR -- requirements
Module: n_bitsubtractor

Interface
REQ-001 Parameter N, default 32: operand and result width in bits.
REQ-002 Parameter CHUNK, default 4: bits processed per cycle; N SHALL be an integer multiple of CHUNK.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operands presented.
REQ-006 in_ready  output  1  block accepts operands.
REQ-007 input1  input  N  minuend.
REQ-008 input2  input  N  subtrahend.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 answer  output  N  input1 - input2, modulo 2^N.
REQ-012 borrow  output  1  1 when unsigned input1 < input2.
REQ-013 ovf  output  1  signed overflow; present only when N_BITSUB_OVF_EN is defined.

Function
REQ-014 FSM SHALL have three states: IDLE, RUN, DONE.
REQ-015 IDLE: in_ready=1; on in_valid&&in_ready, latch input1 and input2, set the chunk index to 0, set the carry to 1, and go to RUN.
REQ-016 RUN: each cycle processes chunk i: sum = a[i] + ~b[i] + carry; write the low CHUNK bits into answer chunk i; carry takes the sum's top bit.
REQ-017 RUN lasts exactly N/CHUNK cycles, then goes to DONE; for the defaults, out_valid rises 8 clocks after the accepting edge.
REQ-018 DONE: out_valid=1; answer, borrow and ovf stay stable until out_valid&&out_ready, then the FSM returns to IDLE.
REQ-019 borrow SHALL equal the inverse of the final carry.
REQ-020 in_ready SHALL be 0 in RUN and DONE; in_valid is ignored in those states and the latched operands do not change.
REQ-021 answer SHALL not be valid outside DONE; intermediate chunk values may be visible.
REQ-022 No overlap: a new operand pair is accepted no earlier than the cycle after the result handshake.
REQ-023 A change on input1 or input2 after acceptance SHALL not affect the result.
REQ-024 Equal operands SHALL give answer=0 and borrow=0.

Reset
REQ-025 While rst=1 at a clock edge: FSM goes to IDLE; in_ready=0 during reset and 1 from the first cycle after; out_valid=0; answer=0; borrow=0; ovf=0; chunk index=0.
REQ-026 Reset during RUN or DONE SHALL abort the operation and discard the result without emitting out_valid.

Configuration
REQ-027 Macro N_BITSUB_OVF_EN defined: the ovf port exists; ovf = (a[N-1] != b[N-1]) && (answer[N-1] != a[N-1]), registered with the other outputs in DONE.
REQ-028 Macro N_BITSUB_OVF_EN undefined: the ovf port and its logic are absent; all other behaviour is unchanged.

Structure
REQ-029 Shared package n_bitadder_pkg SHALL hold the FSM state encoding (IDLE/RUN/DONE) and the default N and CHUNK constants.
REQ-030 One sub-module, n_bitsub_chunk, SHALL hold the combinational CHUNK-bit slice: a, b, cin in; diff, cout out.
REQ-031 The top level SHALL hold the FSM, operand registers, chunk index counter and carry register.

Verification
REQ-032 input1=1209, input2=4565 -> answer=32'hFFFF_F2E4, borrow=1, out_valid 8 clocks after acceptance.
REQ-033 input1=4565, input2=1209 -> answer=32'h0000_0D1C, borrow=0.
REQ-034 input1=0, input2=1 -> answer=32'hFFFF_FFFF, borrow=1; with N_BITSUB_OVF_EN, input1=32'h8000_0000, input2=1 -> answer=32'h7FFF_FFFF, ovf=1.
REQ-035 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and operands -> answer stable, in_ready=0, no second acceptance.
REQ-036 Assert rst at the 4th RUN cycle -> next cycle in IDLE with all outputs 0; a fresh pair 7-7 then gives answer=0, borrow=0.
